poly_div_127: RTL

POLY_DIV_127 -- requirements
Module: poly_div_127

---
 rtl/poly_div_127.sv | 113 +++++++++++
 1 files changed

// File: rtl/poly_div_127.sv
// rtl/poly_div_127.sv - GF(2) polynomial divider, one dividend bit per cycle, MSB first
module poly_div_127 (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [126:0] dividend,
    input  logic [63:0]  divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [126:0] quotient,
    output logic [62:0]  remainder,
    output logic         div_by_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NORM = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]   state;
    logic [126:0] a_reg;
    logic [63:0]  b_reg;
    logic [126:0] q_reg;
    logic [63:0]  r_reg;
    logic [5:0]   d_reg;
    logic [6:0]   cnt;
    logic         dz_reg;

    logic [5:0]   msb_idx;
    logic [63:0]  t;
    logic         t_top;

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign quotient    = q_reg;
    assign remainder   = r_reg[62:0];
    assign div_by_zero = dz_reg;

    // Degree of the captured divisor: index of its highest set bit (0 when divisor is 0 or 1).
    always_comb begin
        msb_idx = 6'd0;
        for (int i = 0; i < 64; i++) begin
            if (b_reg[i]) begin
                msb_idx = 6'(i);
            end
        end
    end

    // One long-division step: shift the next dividend bit into the partial remainder.
    always_comb begin
        t     = {r_reg[62:0], a_reg[cnt]};
        t_top = t[d_reg];
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            q_reg  <= '0;
            r_reg  <= '0;
            d_reg  <= '0;
            cnt    <= '0;
            dz_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= dividend;
                        b_reg <= divisor;
                        q_reg <= '0;
                        r_reg <= '0;
                        state <= NORM;
                    end
                end
                NORM: begin
                    d_reg  <= msb_idx;
                    dz_reg <= (b_reg == 64'd0);
                    // A zero divisor makes a single gated pass through RUN so its
                    // result appears two edges after acceptance.
                    cnt    <= (b_reg == 64'd0) ? 7'd0 : 7'd126;
                    state  <= RUN;
                end
                RUN: begin
                    if (!dz_reg) begin
                        q_reg[cnt] <= t_top;
                        r_reg      <= t ^ (t_top ? b_reg : 64'd0);
                    end
                    if (cnt == 7'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 7'd1;
                    end
                end
                default: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // The partial remainder never reaches the divisor's degree, so its top bit must be clear.
    always @(posedge clk) begin
        if (!rst && state == DONE) begin
            assert (r_reg[63] == 1'b0);
        end
    end

endmodule
